// File: rtl/sliders_edge_irq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sliders_ctrl_pkg
// Description : Shared register map, CTRL bit layout and FSM state type for
//               the slider edge/IRQ controller.
// Revision    : 1.0 - initial release
// ============================================================================
package sliders_ctrl_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd1;
    localparam logic [1:0] ADDR_EDGECAP = 2'd2;
    localparam logic [1:0] ADDR_CTRL    = 2'd3;

    localparam int         CTRL_RISE_BIT = 0;
    localparam int         CTRL_FALL_BIT = 1;
    localparam logic [1:0] CTRL_RESET    = 2'b11;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    typedef enum logic [0:0] {
        INIT = ST_INIT,
        RUN  = ST_RUN
    } fsm_state_e;

endpackage
`default_nettype wire

// File: rtl/sliders_edge_irq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : sliders_edge_irq_ctrl_if
// Description : Avalon-MM slave bus bundle for the slider controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface sliders_edge_irq_ctrl_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface
`default_nettype wire

// File: rtl/sliders_edge_irq_ctrl_debounce.sv
`default_nettype none
// ============================================================================
// Module      : sliders_debounce
// Description : Two-flop synchroniser, sample-tick prescaler, INIT/RUN FSM and
//               per-bit 3-tick agreement filters producing stable levels.
// Revision    : 1.0 - initial release
// ============================================================================
module sliders_debounce
    import sliders_ctrl_pkg::*;
#(
    parameter int WIDTH           = 10,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic [WIDTH-1:0] in_i,
    output logic      [WIDTH-1:0] stable_o,
    output logic      [WIDTH-1:0] rise_o,
    output logic      [WIDTH-1:0] fall_o,
    output logic                  running_o
);

    localparam int               CNT_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0]      meta_q, sync_q;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  tick;
    fsm_state_e            state_q, state_d;
    logic [1:0]            init_cnt_q, init_cnt_d;
    logic [WIDTH-1:0]      stable_q, stable_d;
    logic [WIDTH-1:0][1:0] agree_q, agree_d;
    logic [WIDTH-1:0]      toggle;

    assign tick  = (cnt_q == C_CNT_MAX);
    assign cnt_d = tick ? '0 : cnt_q + 1'b1;

    // A bit flips only on the tick where its third consecutive disagreement lands.
    always_comb begin
        toggle  = '0;
        agree_d = agree_q;
        if (state_q == RUN && tick) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync_q[i] == stable_q[i]) begin
                    agree_d[i] = 2'd0;
                end else if (agree_q[i] == 2'd2) begin
                    agree_d[i] = 2'd0;
                    toggle[i]  = 1'b1;
                end else begin
                    agree_d[i] = agree_q[i] + 2'd1;
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        stable_d   = stable_q ^ toggle;
        if (state_q == INIT && tick) begin
            if (init_cnt_q == 2'd2) begin
                state_d    = RUN;
                init_cnt_d = 2'd0;
                stable_d   = sync_q;
            end else begin
                init_cnt_d = init_cnt_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q     <= '0;
            sync_q     <= '0;
            cnt_q      <= '0;
            state_q    <= INIT;
            init_cnt_q <= 2'd0;
            stable_q   <= '0;
            agree_q    <= '0;
        end else begin
            meta_q     <= in_i;
            sync_q     <= meta_q;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            stable_q   <= stable_d;
            agree_q    <= agree_d;
        end
    end

    assign stable_o  = stable_q;
    assign rise_o    = toggle & ~stable_q;
    assign fall_o    = toggle & stable_q;
    assign running_o = (state_q == RUN);

endmodule
`default_nettype wire

// File: rtl/sliders_edge_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sliders_edge_irq_ctrl
// Description : Avalon-MM slider controller: register file, sticky edge
//               capture, registered read mux and maskable level interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module sliders_edge_irq_ctrl
    import sliders_ctrl_pkg::*;
#(
    parameter int WIDTH           = 10,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  wire logic                clk,
    input  wire logic                reset,
    input  wire logic [WIDTH-1:0]    in_port,
    sliders_edge_irq_ctrl_if.slave   bus,
    output logic                     irq
);

    logic [WIDTH-1:0] stable, rise, fall;
    logic             running;
    logic             wr;
    logic [WIDTH-1:0] edge_clr, edge_set;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [1:0]       ctrl_q, ctrl_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             w_unused_wdata;

    sliders_debounce #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk       (clk),
        .rst       (reset),
        .in_i      (in_port),
        .stable_o  (stable),
        .rise_o    (rise),
        .fall_o    (fall),
        .running_o (running)
    );

    assign wr             = bus.chipselect && !bus.write_n;
    assign w_unused_wdata = ^bus.writedata;

    // Set is OR-ed after the clear so a simultaneous edge keeps the bit.
    always_comb begin
        edge_clr  = (wr && bus.address == ADDR_EDGECAP) ? bus.writedata[WIDTH-1:0] : '0;
        edge_set  = ((rise & {WIDTH{ctrl_q[CTRL_RISE_BIT]}}) |
                     (fall & {WIDTH{ctrl_q[CTRL_FALL_BIT]}})) & {WIDTH{running}};
        edgecap_d = (edgecap_q & ~edge_clr) | edge_set;
        irqmask_d = (wr && bus.address == ADDR_IRQMASK) ? bus.writedata[WIDTH-1:0] : irqmask_q;
        ctrl_d    = (wr && bus.address == ADDR_CTRL) ? bus.writedata[1:0] : ctrl_q;
    end

    always_comb begin
        readdata_d = '0;
        case (bus.address)
            ADDR_DATA:    readdata_d[WIDTH-1:0] = stable;
            ADDR_IRQMASK: readdata_d[WIDTH-1:0] = irqmask_q;
            ADDR_EDGECAP: readdata_d[WIDTH-1:0] = edgecap_q;
            ADDR_CTRL:    readdata_d[1:0]       = ctrl_q;
            default:      readdata_d            = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irqmask_q  <= '0;
            edgecap_q  <= '0;
            ctrl_q     <= CTRL_RESET;
            readdata_q <= '0;
        end else begin
            irqmask_q  <= irqmask_d;
            edgecap_q  <= edgecap_d;
            ctrl_q     <= ctrl_d;
            readdata_q <= readdata_d;
        end
    end

    assign bus.readdata = readdata_q;
    assign irq          = |(edgecap_q & irqmask_q);

endmodule
`default_nettype wire

// File: tb/tb_sliders_edge_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sliders_edge_irq_ctrl
// Description : Self-checking bench for sliders_edge_irq_ctrl against a
//               tick-window reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sliders_edge_irq_ctrl;
    import sliders_ctrl_pkg::*;

    localparam int W  = 10;
    localparam int DC = 4;

    logic         clk     = 1'b0;
    logic         reset   = 1'b1;
    logic [W-1:0] in_port = '0;
    logic         irq;

    sliders_edge_irq_ctrl_if bus ();

    sliders_edge_irq_ctrl #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .in_port (in_port),
        .bus     (bus),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: a level is accepted once the last three tick samples all disagree with it.
    logic [W-1:0] m_in[$];
    logic [W-1:0] m_tsamp[$];
    int           m_e;
    int           m_init_ticks;
    bit           m_run;
    logic [W-1:0] m_stable, m_irqmask, m_edgecap;
    logic [1:0]   m_ctrl;
    logic [31:0]  m_rd;
    bit           m_irq;

    task automatic model_reset();
        m_in.delete();
        m_tsamp.delete();
        m_e          = 0;
        m_init_ticks = 0;
        m_run        = 0;
        m_stable     = '0;
        m_irqmask    = '0;
        m_edgecap    = '0;
        m_ctrl       = 2'b11;
        m_rd         = '0;
        m_irq        = 0;
    endtask

    task automatic model_step();
        logic [W-1:0] samp, chg, cap, clr;
        bit           wr;
        wr = bus.chipselect && !bus.write_n;
        case (bus.address)
            2'd0:    m_rd = 32'(m_stable);
            2'd1:    m_rd = 32'(m_irqmask);
            2'd2:    m_rd = 32'(m_edgecap);
            default: m_rd = 32'(m_ctrl);
        endcase
        samp = (m_in.size() == 2) ? m_in[0] : '0;
        m_in.push_back(in_port);
        if (m_in.size() > 2) void'(m_in.pop_front());
        m_e++;
        chg = '0;
        if (m_e % DC == 0) begin
            if (!m_run) begin
                m_init_ticks++;
                if (m_init_ticks == 3) begin
                    m_stable = samp;
                    m_run    = 1;
                end
            end else begin
                m_tsamp.push_back(samp);
                if (m_tsamp.size() > 3) void'(m_tsamp.pop_front());
                if (m_tsamp.size() == 3)
                    chg = (m_tsamp[0] ^ m_stable) & (m_tsamp[1] ^ m_stable) & (m_tsamp[2] ^ m_stable);
            end
        end
        cap = (chg & ~m_stable & {W{m_ctrl[0]}}) | (chg & m_stable & {W{m_ctrl[1]}});
        m_stable  = m_stable ^ chg;
        clr       = (wr && bus.address == 2'd2) ? bus.writedata[W-1:0] : '0;
        m_edgecap = (m_edgecap & ~clr) | cap;
        if (wr && bus.address == 2'd1) m_irqmask = bus.writedata[W-1:0];
        if (wr && bus.address == 2'd3) m_ctrl = bus.writedata[1:0];
        m_irq = |(m_edgecap & m_irqmask);
    endtask

    task automatic cyc();
        @(posedge clk);
        if (reset) model_reset();
        else       model_step();
        #1;
    endtask

    task automatic bus_idle();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.address    = 2'd0;
        bus.writedata  = '0;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.address    = a;
        bus.writedata  = d;
        cyc();
        bus_idle();
    endtask

    task automatic bus_read(input logic [1:0] a);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        bus.address    = a;
        cyc();
        bus_idle();
    endtask

    // Edges from now until the tick on which a held change is accepted.
    function automatic int accept_edges();
        int k = 3;
        while ((m_e + k) % DC != 0) k++;
        return k + 2 * DC;
    endfunction

    task automatic test_reset();
        reset   = 1'b1;
        in_port = 10'h3FF;
        bus_idle();
        repeat (2) cyc();
        vectors += 2;
        if (bus.readdata !== 32'h0) begin
            miscompares++; $display("FAIL reset_readdata: got %h expected %h", bus.readdata, 32'h0);
        end
        if (irq !== 1'b0) begin
            miscompares++; $display("FAIL reset_irq: got %b expected 0", irq);
        end
        reset = 1'b0;
        repeat (20) cyc();
        bus_read(ADDR_DATA);
        vectors += 2;
        if (bus.readdata !== 32'h3FF) begin
            miscompares++; $display("FAIL init_data: got %h expected %h", bus.readdata, 32'h3FF);
        end
        if (bus.readdata !== m_rd) begin
            miscompares++; $display("FAIL init_data_model: got %h expected %h", bus.readdata, m_rd);
        end
        bus_read(ADDR_EDGECAP);
        vectors += 2;
        if (bus.readdata !== 32'h0) begin
            miscompares++; $display("FAIL init_edgecap: got %h expected %h", bus.readdata, 32'h0);
        end
        if (irq !== 1'b0) begin
            miscompares++; $display("FAIL init_irq: got %b expected 0", irq);
        end
    endtask

    task automatic test_rise_irq();
        int n;
        in_port = '0;
        repeat (20) cyc();
        bus_write(ADDR_EDGECAP, 32'h3FF);
        bus_write(ADDR_IRQMASK, 32'h008);
        in_port[3] = 1'b1;
        n = 0;
        while (irq !== 1'b1 && n < 40) begin
            cyc();
            n++;
            vectors++;
            if (irq !== m_irq) begin
                miscompares++; $display("FAIL rise_irq_track: got %b expected %b at edge %0d", irq, m_irq, n);
            end
        end
        vectors++;
        if (n < 11 || n > 14) begin
            miscompares++; $display("FAIL rise_latency: got %0d edges expected 11..14", n);
        end
        bus_read(ADDR_DATA);
        vectors++;
        if (bus.readdata !== 32'h008) begin
            miscompares++; $display("FAIL rise_data: got %h expected %h", bus.readdata, 32'h008);
        end
        bus_read(ADDR_EDGECAP);
        vectors += 2;
        if (bus.readdata !== 32'h008) begin
            miscompares++; $display("FAIL rise_edgecap: got %h expected %h", bus.readdata, 32'h008);
        end
        if (irq !== 1'b1) begin
            miscompares++; $display("FAIL rise_irq: got %b expected 1", irq);
        end
        bus_write(ADDR_EDGECAP, 32'h008);
        vectors++;
        if (irq !== 1'b0) begin
            miscompares++; $display("FAIL clear_irq: got %b expected 0", irq);
        end
    endtask

    task automatic test_glitch();
        bus_write(ADDR_IRQMASK, 32'h3FF);
        in_port[5] = 1'b1;
        repeat (8) cyc();
        in_port[5] = 1'b0;
        repeat (30) begin
            cyc();
            vectors++;
            if (irq !== 1'b0) begin
                miscompares++; $display("FAIL glitch_irq: got %b expected 0", irq);
            end
        end
        bus_read(ADDR_DATA);
        vectors++;
        if (bus.readdata !== 32'h008) begin
            miscompares++; $display("FAIL glitch_data: got %h expected %h", bus.readdata, 32'h008);
        end
        bus_read(ADDR_EDGECAP);
        vectors++;
        if (bus.readdata !== 32'h0) begin
            miscompares++; $display("FAIL glitch_edgecap: got %h expected %h", bus.readdata, 32'h0);
        end
    endtask

    task automatic test_ctrl_fall_only();
        bus_write(ADDR_CTRL, 32'h2);
        bus_read(ADDR_CTRL);
        vectors++;
        if (bus.readdata !== 32'h2) begin
            miscompares++; $display("FAIL ctrl_read: got %h expected %h", bus.readdata, 32'h2);
        end
        in_port[0] = 1'b1;
        repeat (20) cyc();
        bus_read(ADDR_EDGECAP);
        vectors++;
        if (bus.readdata !== 32'h0) begin
            miscompares++; $display("FAIL fall_only_after_rise: got %h expected %h", bus.readdata, 32'h0);
        end
        in_port[0] = 1'b0;
        repeat (20) cyc();
        bus_read(ADDR_EDGECAP);
        vectors += 2;
        if (bus.readdata !== 32'h001) begin
            miscompares++; $display("FAIL fall_only_after_fall: got %h expected %h", bus.readdata, 32'h001);
        end
        if (irq !== 1'b1) begin
            miscompares++; $display("FAIL fall_only_irq: got %b expected 1", irq);
        end
        bus_write(ADDR_EDGECAP, 32'h3FF);
        bus_write(ADDR_CTRL, 32'h3);
    endtask

    task automatic test_set_vs_clear();
        int k;
        in_port[2] = 1'b1;
        k = accept_edges();
        repeat (k - 1) cyc();
        bus_write(ADDR_EDGECAP, 32'h004);
        bus_read(ADDR_EDGECAP);
        vectors += 2;
        if (bus.readdata !== 32'h004) begin
            miscompares++; $display("FAIL set_wins_edgecap: got %h expected %h", bus.readdata, 32'h004);
        end
        if (irq !== 1'b1) begin
            miscompares++; $display("FAIL set_wins_irq: got %b expected 1", irq);
        end
        bus_read(ADDR_DATA);
        vectors++;
        if (bus.readdata !== 32'h00C) begin
            miscompares++; $display("FAIL set_wins_data: got %h expected %h", bus.readdata, 32'h00C);
        end
        bus_write(ADDR_EDGECAP, 32'h3FF);
    endtask

    task automatic test_reset_mid_filter();
        int k;
        in_port[7] = 1'b1;
        k = accept_edges();
        repeat (k - 2) cyc();
        reset = 1'b1;
        model_reset();
        #1;
        vectors += 2;
        if (bus.readdata !== 32'h0) begin
            miscompares++; $display("FAIL midreset_readdata: got %h expected %h", bus.readdata, 32'h0);
        end
        if (irq !== 1'b0) begin
            miscompares++; $display("FAIL midreset_irq: got %b expected 0", irq);
        end
        repeat (2) cyc();
        reset = 1'b0;
        repeat (4) cyc();
        bus_read(ADDR_DATA);
        vectors++;
        if (bus.readdata !== 32'h0) begin
            miscompares++; $display("FAIL midreset_init_data: got %h expected %h", bus.readdata, 32'h0);
        end
        repeat (14) cyc();
        bus_read(ADDR_DATA);
        vectors++;
        if (bus.readdata !== 32'h08C) begin
            miscompares++; $display("FAIL midreset_run_data: got %h expected %h", bus.readdata, 32'h08C);
        end
        bus_read(ADDR_EDGECAP);
        vectors++;
        if (bus.readdata !== 32'h0) begin
            miscompares++; $display("FAIL midreset_edgecap: got %h expected %h", bus.readdata, 32'h0);
        end
    endtask

    task automatic test_random();
        int hold = 0;
        for (int i = 0; i < 600; i++) begin
            if (hold == 0) begin
                in_port = in_port ^ W'($urandom_range(0, 1023) & $urandom_range(0, 1023));
                hold    = $urandom_range(1, 24);
            end
            hold--;
            if ($urandom_range(0, 9) < 3) begin
                bus.chipselect = 1'b1;
                bus.write_n    = ($urandom_range(0, 2) != 0);
                bus.address    = 2'($urandom_range(0, 3));
                bus.writedata  = $urandom;
            end else begin
                bus_idle();
                bus.address = 2'($urandom_range(0, 3));
            end
            cyc();
            vectors += 2;
            if (bus.readdata !== m_rd) begin
                miscompares++; $display("FAIL random_readdata: got %h expected %h at step %0d", bus.readdata, m_rd, i);
            end
            if (irq !== m_irq) begin
                miscompares++; $display("FAIL random_irq: got %b expected %b at step %0d", irq, m_irq, i);
            end
        end
        bus_idle();
    endtask

    initial begin
        model_reset();
        bus_idle();
        test_reset();
        test_rise_irq();
        test_glitch();
        test_ctrl_fall_only();
        test_set_vs_clear();
        test_reset_mid_filter();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
